// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared widths and host FSM state encoding for the aes SPI host.
package aes_spi_pkg;
   localparam int KEY_BITS   = 128;
   localparam int BLOCK_BITS = 128;
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      LOAD_SETUP   = 3'd1,
      SHIFT_IN     = 3'd2,
      LOAD_RELEASE = 3'd3,
      WAIT_DONE    = 3'd4,
      SHIFT_OUT    = 3'd5
   } host_state_t;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period divider producing mode-0 sck plus edge strobes and setup ticks.
module spi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic toggle_en,
   output logic sck,
   output logic tick,
   output logic rise_en,
   output logic fall_en
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   // strobes fire in the cycle before sck actually changes
   assign tick    = en && (cnt == CW'(CLK_DIV - 1));
   assign rise_en = tick && toggle_en && !sck;
   assign fall_en = tick && toggle_en && sck;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         sck <= (rise_en || fall_en) ? ~sck : sck;
      end
   end
endmodule

// File: rtl/aes_spi_host.sv
// aes_spi_host: SPI initiator that loads key/plaintext into the aes peripheral and reads back the cyphertext.
module aes_spi_host
   import aes_spi_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int DONE_TIMEOUT = 65535
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [KEY_BITS-1:0]   key,
   input  logic [BLOCK_BITS-1:0] plaintext,
   output logic [BLOCK_BITS-1:0] cyphertext,
   output logic                  result_valid,
   output logic                  timeout_err,
   output logic                  busy,
   output logic                  sck,
   output logic                  sdi,
   input  logic                  sdo,
   output logic                  load,
   input  logic                  done
);
   localparam int TX_BITS = KEY_BITS + BLOCK_BITS;
   localparam int TW      = $clog2(DONE_TIMEOUT + 1);
   host_state_t            state;
   logic [TX_BITS-1:0]     tx_sr;
   logic [BLOCK_BITS-1:0]  rx_sr;
   logic [8:0]             bit_cnt;
   logic [TW-1:0]          timer;
   logic [1:0]             done_q;
   logic                   done_sync, gen_en, gen_tog, tick, rise_en, fall_en, last_in, last_out;
   assign done_sync = done_q[1];
   assign gen_en    = state inside {LOAD_SETUP, SHIFT_IN, LOAD_RELEASE, SHIFT_OUT};
   // the setup tick doubles as the first rising edge of the load phase
   assign gen_tog   = state inside {LOAD_SETUP, SHIFT_IN, SHIFT_OUT};
   assign load      = state inside {LOAD_SETUP, SHIFT_IN, LOAD_RELEASE};
   assign sdi       = load & tx_sr[TX_BITS-1];
   assign busy      = state != IDLE;
   assign last_in   = bit_cnt == 9'd255;
   assign last_out  = bit_cnt == 9'd127;
   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (gen_en),
      .toggle_en (gen_tog),
      .sck       (sck),
      .tick      (tick),
      .rise_en   (rise_en),
      .fall_en   (fall_en)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) done_q <= '0;
      else          done_q <= {done_q[0], done};
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         tx_sr        <= '0;
         rx_sr        <= '0;
         bit_cnt      <= '0;
         timer        <= '0;
         cyphertext   <= '0;
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               tx_sr   <= {key, plaintext};
               bit_cnt <= '0;
               state   <= LOAD_SETUP;
            end
            LOAD_SETUP: if (tick) state <= SHIFT_IN;
            SHIFT_IN: if (fall_en) begin
               tx_sr   <= {tx_sr[TX_BITS-2:0], 1'b0};
               bit_cnt <= last_in ? '0 : bit_cnt + 9'd1;
               state   <= last_in ? LOAD_RELEASE : SHIFT_IN;
            end
            LOAD_RELEASE: if (tick) begin
               timer <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done_sync) state <= SHIFT_OUT;
               else if (timer == TW'(DONE_TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else timer <= timer + 1'b1;
            end
            SHIFT_OUT: begin
               if (rise_en) rx_sr <= {rx_sr[BLOCK_BITS-2:0], sdo};
               if (fall_en) begin
                  bit_cnt <= last_out ? '0 : bit_cnt + 9'd1;
                  if (last_out) begin
                     cyphertext   <= rx_sr;
                     result_valid <= 1'b1;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
